muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_if.sv | 43 ++++
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/result handshake and shared-ALU port bundle for muldiv_sequencer.
// With MULDIV_SIGNED_EN defined the bundle also carries op_signed.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
`ifdef MULDIV_SIGNED_EN
    logic             op_signed;
`endif
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_result;

`ifdef MULDIV_SIGNED_EN
    modport master (
        output start, op_div, op_signed, op_a, op_b, alu_result,
        input  busy, done, hi, lo, div_by_zero, alu_op, alu_a, alu_b, alu_shamt
    );
    modport slave (
        input  start, op_div, op_signed, op_a, op_b, alu_result,
        output busy, done, hi, lo, div_by_zero, alu_op, alu_a, alu_b, alu_shamt
    );
`else
    modport master (
        output start, op_div, op_a, op_b, alu_result,
        input  busy, done, hi, lo, div_by_zero, alu_op, alu_a, alu_b, alu_shamt
    );
    modport slave (
        input  start, op_div, op_a, op_b, alu_result,
        output busy, done, hi, lo, div_by_zero, alu_op, alu_a, alu_b, alu_shamt
    );
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multu/divu sequencer time-sharing one external 32-bit ALU (add/sub).
// Define MULDIV_SIGNED_EN for signed mult/div support via a final SIGN state.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam logic [3:0]       ALU_ADD   = 4'b0010;
    localparam logic [3:0]       ALU_SUB   = 4'b0110;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;     // P_hi for multiply, partial remainder for divide
    logic [WIDTH-1:0] acc_lo;     // P_lo for multiply, quotient for divide
    logic [WIDTH-1:0] operand;    // multiplicand or divisor
    logic             is_div;
    logic             dbz_pending;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] r_shift;
    logic             r_top;
    logic [WIDTH-1:0] mul_sum;
    logic             mul_carry;
    logic             div_take;

`ifdef MULDIV_SIGNED_EN
    logic               a_neg;
    logic               b_neg;
    logic               neg_main;
    logic               neg_rem;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        a_neg    = bus.op_signed & bus.op_a[WIDTH-1];
        b_neg    = bus.op_signed & bus.op_b[WIDTH-1];
        mag_a    = a_neg ? -bus.op_a : bus.op_a;
        mag_b    = b_neg ? -bus.op_b : bus.op_b;
        prod_neg = -{acc_hi, acc_lo};
    end
`else
    always_comb begin
        mag_a = bus.op_a;
        mag_b = bus.op_b;
    end
`endif

    assign bus.alu_shamt = '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bus.alu_op = ALU_ADD;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        r_top      = acc_hi[WIDTH-1];
        r_shift    = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        if (state == ITER) begin
            bus.alu_op = is_div ? ALU_SUB : ALU_ADD;
            bus.alu_a  = is_div ? r_shift : acc_hi;
            bus.alu_b  = operand;
        end
        // The ALU has no carry/borrow out, so both are recovered from its sum here.
        mul_sum   = acc_lo[0] ? bus.alu_result : acc_hi;
        mul_carry = acc_lo[0] && (bus.alu_result < acc_hi);
        div_take  = r_top || (r_shift >= operand);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            operand         <= '0;
            is_div          <= 1'b0;
            dbz_pending     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_main        <= 1'b0;
            neg_rem         <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy still covers the done cycle, which keeps start out until after it.
                    if (bus.done) bus.busy <= 1'b0;
                    if (bus.start && !bus.busy) begin
                        bus.busy        <= 1'b1;
                        bus.div_by_zero <= 1'b0;
                        cnt             <= '0;
                        is_div          <= bus.op_div;
`ifdef MULDIV_SIGNED_EN
                        neg_main        <= a_neg ^ b_neg;
                        neg_rem         <= a_neg;
`endif
                        if (bus.op_div && bus.op_b == '0) begin
                            acc_hi      <= bus.op_a;
                            acc_lo      <= '1;
                            dbz_pending <= 1'b1;
                            state       <= DONE;
                        end else begin
                            acc_hi      <= '0;
                            acc_lo      <= bus.op_div ? mag_a : mag_b;
                            operand     <= bus.op_div ? mag_b : mag_a;
                            dbz_pending <= 1'b0;
                            state       <= ITER;
                        end
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_take ? bus.alu_result : r_shift;
                        acc_lo <= {acc_lo[WIDTH-2:0], div_take};
                    end else begin
                        acc_hi <= {mul_carry, mul_sum[WIDTH-1:1]};
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == LAST_ITER) begin
`ifdef MULDIV_SIGNED_EN
                        state <= SIGN;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef MULDIV_SIGNED_EN
                SIGN: begin
                    if (is_div) begin
                        if (neg_main) acc_lo <= -acc_lo;
                        if (neg_rem)  acc_hi <= -acc_hi;
                    end else if (neg_main) begin
                        {acc_hi, acc_lo} <= prod_neg;
                    end
                    state <= DONE;
                end
`endif
                DONE: begin
                    bus.hi          <= acc_hi;
                    bus.lo          <= acc_lo;
                    bus.div_by_zero <= dbz_pending;
                    bus.done        <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops checked
// against an arithmetic reference model; honours MULDIV_SIGNED_EN when defined.
module tb_muldiv_sequencer;
    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared MIPS ALU.
    always_comb begin
        case (bus.alu_op)
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
        return (sgn && v[31]) ? 32'(-v) : v;
    endfunction

    // Reference: results straight from integer arithmetic.
    task automatic model(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output bit dbz);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        if (div && b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dbz = 1'b1;
        end else if (!div) begin
            p  = sgn ? 64'(sa * sb) : 64'(a) * 64'(b);
            hi = p[63:32];
            lo = p[31:0];
        end else if (sgn) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    task automatic drive(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        bus.op_div = div;
        bus.op_a   = a;
        bus.op_b   = b;
`ifdef MULDIV_SIGNED_EN
        bus.op_signed = sgn;
`else
        if (sgn) $display("note: signed request issued to unsigned build");
`endif
    endtask

    // Issue one request, follow it to done, and compare everything observable.
    task automatic run_op(input string tag, input bit div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        bit          e_dbz;
        int          n;
        int          exp_lat;
        bit          busy_ok;
        model(div, sgn, a, b, e_hi, e_lo, e_dbz);
        exp_lat = e_dbz ? 1 : LAT;
        bus.start = 1'b1;
        drive(div, sgn, a, b);
        tick();
        bus.start = 1'b0;
        drive(~div, sgn, ~a, ~b);
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (n == 3 && !e_dbz) begin
                check({tag, ":hold"}, {bus.hi, bus.lo}, {prev_hi, prev_lo});
                check({tag, ":iter_op"}, 64'(bus.alu_op), div ? 64'h6 : 64'h2);
                check({tag, ":iter_b"}, 64'(bus.alu_b), 64'(div ? mag(sgn, b) : mag(sgn, a)));
            end
            bus.start = (n == pulse_at);
            tick();
            n++;
        end
        bus.start = 1'b0;
        check({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check({tag, ":busy"}, 64'(busy_ok && bus.busy === 1'b1), 64'd1);
        check({tag, ":hi"}, 64'(bus.hi), 64'(e_hi));
        check({tag, ":lo"}, 64'(bus.lo), 64'(e_lo));
        check({tag, ":dbz"}, 64'(bus.div_by_zero), 64'(e_dbz));
        prev_hi = e_hi;
        prev_lo = e_lo;
        tick();
        check({tag, ":after"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({tag, ":idle_alu"}, {bus.alu_op, bus.alu_a, bus.alu_b}, {4'h2, 32'd0, 32'd0});
    endtask

    initial begin
        int  n;
        bit  saw_done;
        reset     = 1'b1;
        bus.start = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset:ctl", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        check("reset:hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset:alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {4'h2, 32'd0, 32'd0});
        check("reset:shamt", 64'(bus.alu_shamt), 64'd0);

        run_op("mul7x6", 1'b0, 1'b0, 32'd7, 32'd6, -1);
        run_op("mul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("div100_7", 1'b1, 1'b0, 32'd100, 32'd7, 5);
        run_op("div5_0", 1'b1, 1'b0, 32'd5, 32'd0, -1);
        run_op("div_big", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, -1);

        // Abort a multiply with reset partway through.
        bus.start = 1'b1;
        drive(1'b0, 1'b0, 32'h1234, 32'h5678);
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort:ctl", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        check("abort:hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort:alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {4'h2, 32'd0, 32'd0});
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("abort:no_done", 64'(saw_done), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        run_op("mul3x3", 1'b0, 1'b0, 32'd3, 32'd3, -1);

        // start raised during the done cycle must wait until the cycle after.
        bus.start = 1'b1;
        drive(1'b0, 1'b0, 32'd11, 32'd13);
        tick();
        drive(1'b1, 1'b0, 32'd1000, 32'd10);
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("b2b:first_lo", 64'(bus.lo), 64'd143);
        prev_hi = 32'd0;
        prev_lo = 32'd143;
        tick();
        check("b2b:ignored_in_done", 64'(bus.busy), 64'd0);
        run_op("b2b:div", 1'b1, 1'b0, 32'd1000, 32'd10, -1);

`ifdef MULDIV_SIGNED_EN
        run_op("smul-8x3", 1'b0, 1'b1, 32'hFFFF_FFF8, 32'd3, -1);
        run_op("sdiv-7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("sdiv-5/0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, -1);
`endif

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          div;
            bit          sgn;
            div = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
`ifdef MULDIV_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`else
            sgn = 1'b0;
`endif
            run_op($sformatf("rand%0d", i), div, sgn, a, b, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
